// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO and serializes each word
// as a UART frame (start bit, B data bits LSB first, STOP_BITS stop bits).
module fifo_uart_tx #(
    parameter int unsigned B         = 8,
    parameter int unsigned DIV       = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         empty,
    input  logic [B-1:0] rd_data,
    output logic         rd,
    output logic         tx,
    output logic         busy
);
    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(B - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [SW-1:0] STOP_ONE  = SW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [SW-1:0] stop_q, stop_d;
    logic [B-1:0]  shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic tick_last;
    logic frame_end;

    assign tick_last = (tick_q == TICK_LAST);
    assign frame_end = (state_q == STOP) && tick_last && (stop_q == STOP_LAST);

    // Fetching on the final stop cycle lets the next start bit follow with no gap.
    assign rd   = ~reset & ~empty & ((state_q == IDLE) | frame_end);
    assign tx   = tx_q;
    assign busy = busy_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    shift_d = rd_data;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        stop_d  = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            STOP: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (stop_q == STOP_LAST) begin
                        stop_d = '0;
                        if (rd) begin
                            shift_d = rd_data;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = stop_q + STOP_ONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they never glitch.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds two DUTs (1 and 2 stop
// bits); monitors decode the serial line and compare against queued bytes.
module tb_fifo_uart_tx;
    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       empty0, empty1;
    logic [7:0] rd_data0, rd_data1;
    logic       rd0, rd1, tx0, tx1, busy0, busy1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] fq0[$], fq1[$], pend0[$], pend1[$], expq0[$], expq1[$];
    int busy_cnt[2], rd_cnt[2], rd_last[2], rd_prev[2];
    int start_last[2], start_prev[2];
    int rd_empty_bad = 0;
    int rd_reset_bad = 0;

    fifo_uart_tx #(.B(8), .DIV(DIV), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(rst), .empty(empty0), .rd_data(rd_data0),
        .rd(rd0), .tx(tx0), .busy(busy0)
    );

    fifo_uart_tx #(.B(8), .DIV(DIV), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(rst), .empty(empty1), .rd_data(rd_data1),
        .rd(rd1), .tx(tx1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic tx_of(input int i);
        return (i == 0) ? tx0 : tx1;
    endfunction

    function automatic logic busy_of(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    task automatic push(input int i, input logic [7:0] b, input bit exp_frame);
        if (i == 0) begin
            pend0.push_back(b);
            if (exp_frame) expq0.push_back(b);
        end else begin
            pend1.push_back(b);
            if (exp_frame) expq1.push_back(b);
        end
    endtask

    // FIFO model: pops on the edge that ends an rd cycle, new words appear just after an edge.
    initial begin : fifo_model
        logic r0, r1;
        empty0 = 1'b1; empty1 = 1'b1;
        rd_data0 = '0; rd_data1 = '0;
        forever begin
            @(negedge clk);
            r0 = rd0;
            r1 = rd1;
            if (busy0) busy_cnt[0]++;
            if (busy1) busy_cnt[1]++;
            if (r0) begin rd_cnt[0]++; rd_prev[0] = rd_last[0]; rd_last[0] = cyc; end
            if (r1) begin rd_cnt[1]++; rd_prev[1] = rd_last[1]; rd_last[1] = cyc; end
            if ((r0 && empty0) || (r1 && empty1)) rd_empty_bad++;
            if (rst && (r0 || r1)) rd_reset_bad++;
            @(posedge clk);
            #1;
            if (r0 && !rst && fq0.size() > 0) void'(fq0.pop_front());
            if (r1 && !rst && fq1.size() > 0) void'(fq1.pop_front());
            while (pend0.size() > 0) fq0.push_back(pend0.pop_front());
            while (pend1.size() > 0) fq1.push_back(pend1.pop_front());
            empty0 = (fq0.size() == 0);
            empty1 = (fq1.size() == 0);
            rd_data0 = empty0 ? 8'h00 : fq0[0];
            rd_data1 = empty1 ? 8'h00 : fq1[0];
        end
    end

    task automatic monitor(input int i, input int sb);
        logic [7:0] b;
        logic [7:0] e;
        logic v;
        bit ok, abort;
        int st, nb;
        forever begin
            @(negedge clk);
            if (rst || tx_of(i)) continue;
            st = cyc; b = '0; ok = 1; abort = 0;
            nb = (1 + 8 + sb) * DIV;
            for (int n = 0; n < nb; n++) begin
                if (n > 0) @(negedge clk);
                if (rst) begin abort = 1; break; end
                v = tx_of(i);
                if (!busy_of(i)) ok = 0;
                if (n < DIV) begin
                    if (v) ok = 0;
                end else if (n < 9 * DIV) begin
                    if (n % DIV == 0) b[n / DIV - 1] = v;
                    else if (v != b[n / DIV - 1]) ok = 0;
                end else if (!v) begin
                    ok = 0;
                end
            end
            if (!abort) begin
                start_prev[i] = start_last[i];
                start_last[i] = st;
                if ((i == 0 && expq0.size() == 0) || (i == 1 && expq1.size() == 0)) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_unexpected[%0d]: got byte 0x%02h, required no frame", i, b);
                end else begin
                    if (i == 0) e = expq0.pop_front();
                    else e = expq1.pop_front();
                    check($sformatf("frame_byte[%0d]", i), int'(b), int'(e));
                    check($sformatf("frame_shape[%0d]", i), int'(ok), 1);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0, 1);
            monitor(1, 2);
        join_none
    end

    task automatic wait_done(input int i, input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            @(negedge clk);
            if (i == 0 && expq0.size() == 0 && !busy0 && empty0) break;
            if (i == 1 && expq1.size() == 0 && !busy1 && empty1) break;
        end
        check($sformatf("drain_timeout[%0d]", i), int'(t < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int b0, rc, t, bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx0", int'(tx0), 1);
        check("reset_busy0", int'(busy0), 0);
        check("reset_rd0", int'(rd0), 0);
        check("reset_tx1", int'(tx1), 1);
        check("reset_busy1", int'(busy1), 0);
        @(posedge clk); #2 rst = 1'b0;

        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rd0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        check("idle_200", bad, 0);

        // single 0xA5 frame
        b0 = busy_cnt[0]; rc = rd_cnt[0];
        push(0, 8'hA5, 1);
        for (t = 0; t < 10 && empty0; t++) @(negedge clk);
        check("rdA_first", int'(rd0), 1);
        check("busyA_pre", int'(busy0), 0);
        @(negedge clk);
        check("txA_fall", int'(tx0), 0);
        check("busyA_rise", int'(busy0), 1);
        wait_done(0, 100);
        check("busyA_len", busy_cnt[0] - b0, 40);
        check("rdA_pulses", rd_cnt[0] - rc, 1);
        check("emptyA", int'(empty0), 1);

        // preloaded 0x00, 0xFF back to back
        b0 = busy_cnt[0]; rc = rd_cnt[0];
        push(0, 8'h00, 1);
        push(0, 8'hFF, 1);
        wait_done(0, 200);
        check("rdB_pulses", rd_cnt[0] - rc, 2);
        check("rdB_spacing", rd_last[0] - rd_prev[0], 40);
        check("frameB_period", start_last[0] - start_prev[0], 40);
        check("busyB_len", busy_cnt[0] - b0, 80);

        // reset during data bit 3 of 0x3C, then 0x81
        rc = rd_cnt[0];
        push(0, 8'h3C, 0);
        for (t = 0; t < 10 && tx0; t++) @(negedge clk);
        check("txC_start", int'(tx0), 0);
        repeat (17) @(negedge clk);
        check("txC_bit3", int'(tx0), 1);
        check("busyC_pre", int'(busy0), 1);
        #2 rst = 1'b1;
        #1;
        check("rstC_tx", int'(tx0), 1);
        check("rstC_busy", int'(busy0), 0);
        push(0, 8'h81, 1);
        repeat (4) @(negedge clk);
        check("rstC_empty", int'(empty0), 0);
        check("rstC_rd", int'(rd0), 0);
        @(posedge clk); #2 rst = 1'b0;
        wait_done(0, 100);
        check("rdC_pulses", rd_cnt[0] - rc, 2);

        // two stop bits, 0x55 twice
        b0 = busy_cnt[1]; rc = rd_cnt[1];
        push(1, 8'h55, 1);
        push(1, 8'h55, 1);
        wait_done(1, 200);
        check("rdD_pulses", rd_cnt[1] - rc, 2);
        check("rdD_spacing", rd_last[1] - rd_prev[1], 44);
        check("frameD_period", start_last[1] - start_prev[1], 44);
        check("busyD_len", busy_cnt[1] - b0, 88);

        check("rd_while_empty", rd_empty_bad, 0);
        check("rd_during_reset", rd_reset_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
